// File: rtl/exec_sched.sv
// ============================================================================
// Module   : exec_sched
// Brief    : Execute-stage scheduler time-sharing one ALU between the
//            instruction operation and the branch/jump target add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_sched #(
  parameter int          WIDTH  = 16,
  parameter logic [2:0]  ADD_OP = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       alu_op,
  input  logic             inv_a,
  input  logic             inv_b,
  input  logic             cin,
  input  logic             sign,
  input  logic [WIDTH-1:0] pc_old,
  input  logic [WIDTH-1:0] imm,
  input  logic             is_br,
  input  logic [1:0]       br_cond,
  input  logic             is_jmp,
  input  logic             is_jr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op_o,
  output logic             alu_inv_a,
  output logic             alu_inv_b,
  output logic             alu_cin,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] pc_next,
  output logic             err
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_TGT  = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [2:0]       r_alu_op;
  logic             r_inv_a;
  logic             r_inv_b;
  logic             r_cin;
  logic             r_sign;
  logic [WIDTH-1:0] r_pc_old;
  logic [WIDTH-1:0] r_imm;
  logic             r_is_br;
  logic [1:0]       r_br_cond;
  logic             r_is_jmp;
  logic             r_is_jr;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_pc_next;
  logic             r_err;

  logic             w_accept;
  logic             w_is_ctl;
  logic             w_cond;
  logic             w_taken;
  logic             w_illegal;

  // Back-to-back accept in DONE depends combinationally on out_ready.
  assign in_ready  = (r_state == c_ST_IDLE) || ((r_state == c_ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == c_ST_DONE);
  assign w_is_ctl  = is_br | is_jmp | is_jr;

  always_comb begin
    w_cond = 1'b0;
    case (r_br_cond)
      2'b00:   w_cond = (r_op_a == '0);
      2'b01:   w_cond = (r_op_a != '0);
      2'b10:   w_cond = r_op_a[WIDTH-1];
      default: w_cond = ~r_op_a[WIDTH-1];
    endcase
  end

  assign w_taken   = r_is_jmp | r_is_jr | (r_is_br & w_cond);
  assign w_illegal = (r_is_br & r_is_jmp) | (r_is_br & r_is_jr) | (r_is_jmp & r_is_jr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_accept) w_state_nxt = w_is_ctl ? c_ST_TGT : c_ST_EXEC;
      c_ST_EXEC: w_state_nxt = c_ST_DONE;
      c_ST_TGT:  w_state_nxt = c_ST_DONE;
      c_ST_DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_nxt = w_is_ctl ? c_ST_TGT : c_ST_EXEC;
          else          w_state_nxt = c_ST_IDLE;
        end
      end
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op_o  = ADD_OP;
    alu_inv_a = 1'b0;
    alu_inv_b = 1'b0;
    alu_cin   = 1'b0;
    alu_sign  = 1'b0;
    case (r_state)
      c_ST_EXEC: begin
        alu_a     = r_op_a;
        alu_b     = r_op_b;
        alu_op_o  = r_alu_op;
        alu_inv_a = r_inv_a;
        alu_inv_b = r_inv_b;
        alu_cin   = r_cin;
        alu_sign  = r_sign;
      end
      c_ST_TGT: begin
        // jr takes its base from rs; jmp/br are PC-relative
        alu_a    = r_is_jr ? r_op_a : r_pc_old;
        alu_b    = r_imm;
        alu_sign = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_alu_op  <= '0;
      r_inv_a   <= 1'b0;
      r_inv_b   <= 1'b0;
      r_cin     <= 1'b0;
      r_sign    <= 1'b0;
      r_pc_old  <= '0;
      r_imm     <= '0;
      r_is_br   <= 1'b0;
      r_br_cond <= '0;
      r_is_jmp  <= 1'b0;
      r_is_jr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a    <= op_a;
        r_op_b    <= op_b;
        r_alu_op  <= alu_op;
        r_inv_a   <= inv_a;
        r_inv_b   <= inv_b;
        r_cin     <= cin;
        r_sign    <= sign;
        r_pc_old  <= pc_old;
        r_imm     <= imm;
        r_is_br   <= is_br;
        r_br_cond <= br_cond;
        r_is_jmp  <= is_jmp;
        r_is_jr   <= is_jr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_pc_next <= '0;
      r_err     <= 1'b0;
    end else if (r_state == c_ST_EXEC) begin
      r_result  <= alu_out;
      r_pc_next <= r_pc_old;
      r_err     <= 1'b0;
    end else if (r_state == c_ST_TGT) begin
      r_result  <= '0;
      r_pc_next <= w_taken ? alu_out : r_pc_old;
      r_err     <= (w_taken & alu_ofl) | w_illegal;
    end
  end

  assign result  = r_result;
  assign pc_next = r_pc_next;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_exec_sched.sv
// ============================================================================
// Module   : tb_exec_sched
// Brief    : Directed self-checking bench for exec_sched with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] op_a, op_b, pc_old, imm;
  logic [2:0]  alu_op;
  logic        inv_a, inv_b, cin, sign;
  logic        is_br, is_jmp, is_jr;
  logic [1:0]  br_cond;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op_o;
  logic        alu_inv_a, alu_inv_b, alu_cin, alu_sign, alu_ofl;
  logic        out_valid, out_ready;
  logic [15:0] result, pc_next;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_a, m_b;
  logic [16:0] m_sum;

  always #5 clk = ~clk;

  exec_sched #(.WIDTH(16), .ADD_OP(3'b100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .inv_a(inv_a), .inv_b(inv_b),
    .cin(cin), .sign(sign), .pc_old(pc_old), .imm(imm), .is_br(is_br),
    .br_cond(br_cond), .is_jmp(is_jmp), .is_jr(is_jr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_o(alu_op_o), .alu_inv_a(alu_inv_a),
    .alu_inv_b(alu_inv_b), .alu_cin(alu_cin), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .pc_next(pc_next), .err(err)
  );

  // Behavioural shared ALU: 100 = add, 111 = xor
  always_comb begin
    m_a     = alu_inv_a ? ~alu_a : alu_a;
    m_b     = alu_inv_b ? ~alu_b : alu_b;
    m_sum   = {1'b0, m_a} + {1'b0, m_b} + {16'd0, alu_cin};
    alu_out = 16'h0000;
    alu_ofl = 1'b0;
    case (alu_op_o)
      3'b100: begin
        alu_out = m_sum[15:0];
        alu_ofl = alu_sign ? ((m_a[15] == m_b[15]) && (m_sum[15] != m_a[15])) : m_sum[16];
      end
      3'b111:  alu_out = m_a ^ m_b;
      default: alu_out = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [15:0] pc, input logic [15:0] im, input logic br,
                       input logic [1:0] cond, input logic jmp, input logic jr);
    op_a = a; op_b = b; alu_op = op; inv_a = 1'b0; inv_b = 1'b0; cin = 1'b0; sign = 1'b0;
    pc_old = pc; imm = im; is_br = br; br_cond = cond; is_jmp = jmp; is_jr = jr;
  endtask

  // Accept, ALU phase, hold one cycle with out_ready=1, then drain to IDLE.
  task automatic run_chk(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] eres, input logic [15:0] epc, input logic eerr);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, ".out_valid_c1"}, out_valid, 0);
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    chk({tag, ".alu_a"}, alu_a, ea);
    chk({tag, ".alu_b"}, alu_b, eb);
    step();
    chk({tag, ".out_valid_c2"}, out_valid, 1);
    chk({tag, ".result"}, result, eres);
    chk({tag, ".pc_next"}, pc_next, epc);
    chk({tag, ".err"}, err, eerr);
    step();
    chk({tag, ".out_valid_drain"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(16'h0, 16'h0, 3'b000, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    step();
    chk("reset.out_valid", out_valid, 0);
    chk("reset.result", result, 0);
    chk("reset.pc_next", pc_next, 0);
    chk("reset.err", err, 0);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.alu_op_idle", alu_op_o, 3'b100);
    rst = 1'b0;
    step();

    drive(16'h0003, 16'h0004, 3'b100, 16'h0100, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    run_chk("add", 16'h0003, 16'h0004, 16'h0007, 16'h0100, 1'b0);

    drive(16'h1234, 16'h00FF, 3'b111, 16'h0102, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    run_chk("xor", 16'h1234, 16'h00FF, 16'h12CB, 16'h0102, 1'b0);

    drive(16'h0000, 16'h0000, 3'b000, 16'h0010, 16'hFFF8, 1'b1, 2'b00, 1'b0, 1'b0);
    run_chk("beqz", 16'h0010, 16'hFFF8, 16'h0000, 16'h0008, 1'b0);

    drive(16'h0000, 16'h0000, 3'b000, 16'h0010, 16'hFFF8, 1'b1, 2'b01, 1'b0, 1'b0);
    run_chk("bnez", 16'h0010, 16'hFFF8, 16'h0000, 16'h0010, 1'b0);

    drive(16'h8000, 16'h0000, 3'b000, 16'h0100, 16'h0020, 1'b1, 2'b10, 1'b0, 1'b0);
    run_chk("bltz", 16'h0100, 16'h0020, 16'h0000, 16'h0120, 1'b0);

    drive(16'h8000, 16'h0000, 3'b000, 16'h0100, 16'h0020, 1'b1, 2'b11, 1'b0, 1'b0);
    run_chk("bgez", 16'h0100, 16'h0020, 16'h0000, 16'h0100, 1'b0);

    drive(16'h7FFE, 16'h0000, 3'b000, 16'h0020, 16'h0004, 1'b0, 2'b00, 1'b0, 1'b1);
    run_chk("jr_ofl", 16'h7FFE, 16'h0004, 16'h0000, 16'h8002, 1'b1);

    drive(16'h0005, 16'h0000, 3'b000, 16'h0040, 16'h0010, 1'b1, 2'b00, 1'b1, 1'b0);
    run_chk("illegal", 16'h0040, 16'h0010, 16'h0000, 16'h0050, 1'b1);

    // Backpressure: first bundle held while the next instruction waits.
    out_ready = 1'b0;
    drive(16'h0001, 16'h0002, 3'b100, 16'h0200, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    drive(16'h0010, 16'h0020, 3'b100, 16'h0300, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid_hold", out_valid, 1);
      chk("bp.result_hold", result, 16'h0003);
      chk("bp.pc_hold", pc_next, 16'h0200);
      chk("bp.in_ready_low", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_comb", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp.second_c1", out_valid, 0);
    step();
    chk("bp.second_valid", out_valid, 1);
    chk("bp.second_result", result, 16'h0030);
    chk("bp.second_pc", pc_next, 16'h0300);
    step();
    chk("bp.drain", out_valid, 0);

    // Asynchronous reset in the middle of a target phase.
    drive(16'h0000, 16'h0000, 3'b000, 16'h0400, 16'h0100, 1'b0, 2'b00, 1'b1, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_mid.in_tgt_alu_a", alu_a, 16'h0400);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.pc_next", pc_next, 0);
    chk("rst_mid.in_ready", in_ready, 1);
    step();
    rst = 1'b0;
    step();
    chk("rst_mid.no_output", out_valid, 0);
    chk("rst_mid.pc_still0", pc_next, 0);

    drive(16'h0005, 16'h0006, 3'b100, 16'h0500, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    run_chk("post_rst_add", 16'h0005, 16'h0006, 16'h000B, 16'h0500, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
